// File: rtl/captura_resultados.sv
// captura_resultados: pairs the current/voltage results on the rising edges of
// their completion acknowledges and queues each complete pair in a
// first-word-fall-through FIFO. When the FIFO is full a pair is dropped and
// counted; the datapath is never stalled.
module captura_resultados #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ACK_I,
  input  logic                     ACK_V,
  input  logic [W-1:0]             RESULT_I,
  input  logic [W-1:0]             RESULT_V,
  input  logic                     RD_EN,
  input  logic                     CLR_OVF,
  output logic [W-1:0]             DATA_I_OUT,
  output logic [W-1:0]             DATA_V_OUT,
  output logic                     VALID_OUT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic [7:0]               DROP_CNT
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_V = 2'd1,
    WAIT_I = 2'd2,
    PUSH   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          state_q,    state_d;
  logic            ack_i_q,    ack_v_q;
  logic [W-1:0]    hold_i_q,   hold_i_d;
  logic [W-1:0]    hold_v_q,   hold_v_d;
  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [AW:0]     count_q,    count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [W-1:0]    mem_i_q [DEPTH];
  logic [W-1:0]    mem_v_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic rise_i, rise_v;
  logic push_req;
  logic pop;
  logic wr_ok;
  logic drop;
  logic empty_w, full_w;

  assign rise_i   = ACK_I & ~ack_i_q;
  assign rise_v   = ACK_V & ~ack_v_q;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CNT_FULL);

  // The pair to write is whatever sits in the hold registers while in PUSH.
  assign push_req = (state_q == PUSH);
  assign pop      = RD_EN & ~empty_w;
  // A full FIFO still accepts the write when the head leaves on the same edge.
  assign wr_ok    = push_req & (~full_w | pop);
  assign drop     = push_req & full_w & ~pop;

  // ---------------------------------------------------------------------------
  // ACK edge detectors; preset high so an ACK already up at reset release
  // does not register as a new completion.
  // ---------------------------------------------------------------------------
  // Previous-value registers for the two acknowledges
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_i_q <= 1'b1;
      ack_v_q <= 1'b1;
    end else begin
      ack_i_q <= ACK_I;
      ack_v_q <= ACK_V;
    end
  end

  // ---------------------------------------------------------------------------
  // Result hold registers: capture on every rise, in any FSM state
  // ---------------------------------------------------------------------------
  // Next-value selection for the hold registers
  always_comb begin
    hold_i_d = hold_i_q;
    hold_v_d = hold_v_q;
    if (rise_i) hold_i_d = RESULT_I;
    if (rise_v) hold_v_d = RESULT_V;
  end

  // Hold register update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_i_q <= '0;
      hold_v_q <= '0;
    end else begin
      hold_i_q <= hold_i_d;
      hold_v_q <= hold_v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pairing FSM
  // ---------------------------------------------------------------------------
  // Pairing FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; PUSH decodes this cycle's rises exactly like IDLE so an
  // ACK arriving during the write cycle is not lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PUSH: begin
        if (rise_i && rise_v) state_d = PUSH;
        else if (rise_i)      state_d = WAIT_V;
        else if (rise_v)      state_d = WAIT_I;
        else                  state_d = IDLE;
      end
      WAIT_V: begin
        if (rise_v) state_d = PUSH;
      end
      WAIT_I: begin
        if (rise_i) state_d = PUSH;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; left unreset because the outputs are masked while empty
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem_i_q[wr_ptr_q] <= hold_i_q;
      mem_v_q[wr_ptr_q] <= hold_v_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow reporting
  // ---------------------------------------------------------------------------
  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (CLR_OVF)                 drop_cnt_d = 8'd1;
      else if (drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (CLR_OVF) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Overflow registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign EMPTY      = empty_w;
  assign FULL       = full_w;
  assign VALID_OUT  = ~empty_w;
  assign COUNT      = count_q;
  assign OVERFLOW   = overflow_q;
  assign DROP_CNT   = drop_cnt_q;
  assign DATA_I_OUT = empty_w ? '0 : mem_i_q[rd_ptr_q];
  assign DATA_V_OUT = empty_w ? '0 : mem_v_q[rd_ptr_q];

endmodule

// File: tb/tb_captura_resultados.sv
// Testbench for captura_resultados: directed vector table, hand-written
// corner sequences, and randomized traffic checked every cycle against a
// queue-based reference model.
module tb_captura_resultados;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic          CLK;
  logic          RST;
  logic          ACK_I, ACK_V;
  logic [W-1:0]  RESULT_I, RESULT_V;
  logic          RD_EN, CLR_OVF;
  logic [W-1:0]  DATA_I_OUT, DATA_V_OUT;
  logic          VALID_OUT, EMPTY, FULL;
  logic [3:0]    COUNT;
  logic          OVERFLOW;
  logic [7:0]    DROP_CNT;

  captura_resultados #(.DEPTH(DEPTH), .W(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ACK_I      (ACK_I),
    .ACK_V      (ACK_V),
    .RESULT_I   (RESULT_I),
    .RESULT_V   (RESULT_V),
    .RD_EN      (RD_EN),
    .CLR_OVF    (CLR_OVF),
    .DATA_I_OUT (DATA_I_OUT),
    .DATA_V_OUT (DATA_V_OUT),
    .VALID_OUT  (VALID_OUT),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .COUNT      (COUNT),
    .OVERFLOW   (OVERFLOW),
    .DROP_CNT   (DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pairs plus "have I / have V / write pending"
  // flags, updated once per rising edge from the pre-edge inputs.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] i;
    logic [31:0] v;
  } pair_t;

  pair_t       mq[$];
  logic [31:0] m_hold_i, m_hold_v;
  logic        m_prev_i, m_prev_v;
  logic        m_hi, m_hv, m_pend;
  logic        m_ovf;
  int          m_dcnt;

  always begin
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_hold_i = '0; m_hold_v = '0;
      m_prev_i = 1'b1; m_prev_v = 1'b1;
      m_hi = 1'b0; m_hv = 1'b0; m_pend = 1'b0;
      m_ovf = 1'b0; m_dcnt = 0;
    end else begin
      automatic logic  do_pop   = RD_EN && (mq.size() > 0);
      automatic logic  was_full = (mq.size() == DEPTH);
      automatic logic  drop     = 1'b0;
      automatic pair_t e;
      automatic logic  ri, rv;
      e.i = m_hold_i;
      e.v = m_hold_v;
      if (do_pop) void'(mq.pop_front());
      if (m_pend) begin
        if (!was_full || do_pop) mq.push_back(e);
        else drop = 1'b1;
      end
      if (drop) begin
        m_ovf  = 1'b1;
        m_dcnt = CLR_OVF ? 1 : ((m_dcnt == 255) ? 255 : m_dcnt + 1);
      end else if (CLR_OVF) begin
        m_ovf  = 1'b0;
        m_dcnt = 0;
      end
      ri = ACK_I && !m_prev_i;
      rv = ACK_V && !m_prev_v;
      if (m_pend) begin m_hi = 1'b0; m_hv = 1'b0; end
      if (ri) begin m_hi = 1'b1; m_hold_i = RESULT_I; end
      if (rv) begin m_hv = 1'b1; m_hold_v = RESULT_V; end
      m_pend = m_hi && m_hv;
      if (m_pend) begin m_hi = 1'b0; m_hv = 1'b0; end
      m_prev_i = ACK_I;
      m_prev_v = ACK_V;
    end
    #2;
    if (!RST) begin
      automatic int sz = mq.size();
      chk("mdl_count", 32'(COUNT), 32'(sz));
      chk("mdl_flags", {28'd0, VALID_OUT, EMPTY, FULL, OVERFLOW},
          {28'd0, sz != 0, sz == 0, sz == DEPTH, m_ovf});
      chk("mdl_data_i", DATA_I_OUT, (sz != 0) ? mq[0].i : 32'h0);
      chk("mdl_data_v", DATA_V_OUT, (sz != 0) ? mq[0].v : 32'h0);
      chk("mdl_drop_cnt", 32'(DROP_CNT), 32'(m_dcnt));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ai, av;
    logic [31:0] ri, rv;
    logic        rd;
    int          cnt;
    logic        valid;
    logic [31:0] di, dv;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic pair(input logic [31:0] i, input logic [31:0] v);
    ACK_I = 1'b1; ACK_V = 1'b1; RESULT_I = i; RESULT_V = v;
    tick();
    ACK_I = 1'b0; ACK_V = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; ACK_I = 1'b1; ACK_V = 1'b1;
    RESULT_I = '0; RESULT_V = '0; RD_EN = 1'b0; CLR_OVF = 1'b0;

    //                 ai av ri            rv            rd cnt val di            dv
    tbl[0]  = '{1'b1, 1'b0, 32'h3F800000, 32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h40000000, 1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'hBADBAD00, 1'b0, 1, 1'b1, 32'h3F800000, 32'h40000000};
    tbl[5]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'hBADBAD00, 1'b1, 0, 1'b0, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h1,        32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h2,        32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 1'b1, 32'h0,        32'h3,        1'b0, 0, 1'b0, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1, 1'b1, 32'h2,        32'h3};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0};

    // Reset release with both ACKs already high: no edge, no entry
    tick(); tick();
    RST = 1'b0;
    tick(); tick(); tick();
    chk("rst_empty",    32'(EMPTY),     32'd1);
    chk("rst_count",    32'(COUNT),     32'd0);
    chk("rst_valid",    32'(VALID_OUT), 32'd0);
    chk("rst_full",     32'(FULL),      32'd0);
    chk("rst_data_i",   DATA_I_OUT,     32'h0);
    chk("rst_ovf",      32'(OVERFLOW),  32'd0);
    chk("rst_drop_cnt", 32'(DROP_CNT),  32'd0);

    ACK_I = 1'b0; ACK_V = 1'b0;
    tick();

    for (int k = 0; k < NV; k++) begin
      ACK_I = tbl[k].ai; ACK_V = tbl[k].av;
      RESULT_I = tbl[k].ri; RESULT_V = tbl[k].rv;
      RD_EN = tbl[k].rd;
      tick();
      chk($sformatf("vec%0d_count", k), 32'(COUNT),     32'(tbl[k].cnt));
      chk($sformatf("vec%0d_valid", k), 32'(VALID_OUT), 32'(tbl[k].valid));
      chk($sformatf("vec%0d_di", k),    DATA_I_OUT,     tbl[k].di);
      chk($sformatf("vec%0d_dv", k),    DATA_V_OUT,     tbl[k].dv);
    end
    RD_EN = 1'b0; ACK_I = 1'b0; ACK_V = 1'b0;

    // Ten pairs into an 8-deep FIFO with no reads
    for (int k = 1; k <= 10; k++) pair(32'(k), 32'(k + 100));
    chk("ovf_count",    32'(COUNT),    32'd8);
    chk("ovf_full",     32'(FULL),     32'd1);
    chk("ovf_flag",     32'(OVERFLOW), 32'd1);
    chk("ovf_drop_cnt", 32'(DROP_CNT), 32'd2);
    RD_EN = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("drain%0d_i", j), DATA_I_OUT, 32'(j));
      chk($sformatf("drain%0d_v", j), DATA_V_OUT, 32'(j + 100));
      tick();
    end
    RD_EN = 1'b0;
    chk("drain_empty", 32'(EMPTY), 32'd1);

    // Full FIFO with a write coinciding with a pop: nothing dropped
    for (int k = 11; k <= 18; k++) pair(32'(k), 32'(k + 100));
    ACK_I = 1'b1; ACK_V = 1'b1; RESULT_I = 32'd19; RESULT_V = 32'd119;
    tick();
    ACK_I = 1'b0; ACK_V = 1'b0; RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    chk("fullpop_count",    32'(COUNT),    32'd8);
    chk("fullpop_full",     32'(FULL),     32'd1);
    chk("fullpop_drop_cnt", 32'(DROP_CNT), 32'd2);
    chk("fullpop_head",     DATA_I_OUT,    32'd12);

    // Clear coinciding with a drop: the drop wins
    ACK_I = 1'b1; ACK_V = 1'b1; RESULT_I = 32'd20; RESULT_V = 32'd120;
    tick();
    ACK_I = 1'b0; ACK_V = 1'b0; CLR_OVF = 1'b1;
    tick();
    chk("clrdrop_ovf",      32'(OVERFLOW), 32'd1);
    chk("clrdrop_drop_cnt", 32'(DROP_CNT), 32'd1);
    tick();
    CLR_OVF = 1'b0;
    chk("clr_ovf",      32'(OVERFLOW), 32'd0);
    chk("clr_drop_cnt", 32'(DROP_CNT), 32'd0);
    RD_EN = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain2_%0d_i", j), DATA_I_OUT, 32'(12 + j));
      tick();
    end
    RD_EN = 1'b0;
    chk("drain2_empty", 32'(EMPTY), 32'd1);

    // Reset in WAIT_V discards the half pair; a fresh ACK_V then waits for I
    ACK_I = 1'b1; RESULT_I = 32'hAA;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("rstmid_count", 32'(COUNT), 32'd0);
    ACK_V = 1'b1; RESULT_V = 32'hBB;
    tick(); tick(); tick();
    chk("waiti_count", 32'(COUNT), 32'd0);
    ACK_I = 1'b0;
    tick();
    ACK_I = 1'b1; RESULT_I = 32'hCC;
    tick(); tick();
    chk("waiti_pair_count", 32'(COUNT), 32'd1);
    chk("waiti_pair_i",     DATA_I_OUT,  32'hCC);
    chk("waiti_pair_v",     DATA_V_OUT,  32'hBB);
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0; ACK_I = 1'b0; ACK_V = 1'b0;
    tick();

    // Randomized traffic: heavy overflow first, then mostly draining
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) ACK_I = ~ACK_I;
      if ($urandom_range(0, 2) == 0) ACK_V = ~ACK_V;
      RESULT_I = $urandom;
      RESULT_V = $urandom;
      RD_EN    = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      CLR_OVF  = ($urandom_range(0, 63) == 0);
      RST      = (c == 1200);
      tick();
    end
    RST = 1'b0; RD_EN = 1'b0; CLR_OVF = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/captura_resultados.md
# captura_resultados

Pairing and buffering stage directly downstream of the denormalizer/delinearizer. It watches the two completion acknowledges, ACK_I and ACK_V, and captures RESULT_I and RESULT_V at those events. When both halves of a result pair have been captured, it writes the pair into a first-word-fall-through FIFO. Consumers drain the FIFO with a valid/ready read port, and overflow is reported instead of stalling the datapath.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2.
- W, 32, width of each result word (IEEE-754 single).
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset; one clock, asynchronous, active-high. Clears all state.
- ACK_I  in  1  current-result done; a level, held high until the next operation.
- ACK_V  in  1  voltage-result done; same semantics as ACK_I.
- RESULT_I  in  W  current result; valid whenever ACK_I is high.
- RESULT_V  in  W  voltage result; valid whenever ACK_V is high.
- RD_EN  in  1  consumer ready; pops the head when VALID_OUT=1.
- CLR_OVF  in  1  synchronous clear of OVERFLOW and DROP_CNT.
- DATA_I_OUT  out  W  head-entry current word; 0 when EMPTY.
- DATA_V_OUT  out  W  head-entry voltage word; 0 when EMPTY.
- VALID_OUT  out  1  equals !EMPTY.
- EMPTY  out  1  FIFO holds 0 entries.
- FULL  out  1  FIFO holds DEPTH entries.
- COUNT  out  log2(DEPTH)+1  number of stored entries.
- OVERFLOW  out  1  sticky; set when a pair is dropped.
- DROP_CNT  out  8  dropped-pair count; saturates at 255.

## Operation
- Edge detection: registers ack_i_q and ack_v_q hold the previous values of ACK_I and ACK_V.
  - They reset to 1, so an ACK still high when RST deasserts is not seen as an edge.
  - rise_i = ACK_I & !ack_i_q; rise_v = ACK_V & !ack_v_q.
- On rise_i, hold_i <= RESULT_I. On rise_v, hold_v <= RESULT_V. Capture happens in every state.
- Pairing FSM, states IDLE, WAIT_V, WAIT_I, PUSH:
  - IDLE: both rises -> PUSH; rise_i only -> WAIT_V; rise_v only -> WAIT_I; else stay.
  - WAIT_V: rise_v -> PUSH. A repeated rise_i overwrites hold_i (newest wins) and stays in WAIT_V.
  - WAIT_I: symmetric to WAIT_V.
  - PUSH: write {hold_i, hold_v} as they were before this edge. Next state is computed from this cycle's rises exactly as from IDLE, so no event is lost.
- FIFO write rules:
  - The write is accepted if !FULL, or if FULL and a pop occurs in the same cycle.
  - Otherwise the pair is dropped: OVERFLOW <= 1 and DROP_CNT increments, saturating at 255.
- Pop: occurs when RD_EN & VALID_OUT. RD_EN while EMPTY is ignored and nothing changes.
- Simultaneous write and pop: COUNT is unchanged and both pointers advance.
  - When EMPTY, a push is never combined with a pop in the same cycle. The new entry becomes visible the following cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. FULL and EMPTY are derived from COUNT.
- Storage is not reset; DATA outputs are masked to 0 while EMPTY.
- CLR_OVF clears OVERFLOW and DROP_CNT. If a drop occurs in the same cycle, the drop wins: OVERFLOW=1 and DROP_CNT=1.
- Reset values:
  - State IDLE; COUNT=0; pointers 0; EMPTY=1.
  - FULL=0, VALID_OUT=0, OVERFLOW=0, DROP_CNT=0, DATA outputs 0; ack_*_q=1.
  - A reset during WAIT_* or PUSH discards the partial or pending pair.

## Timing
- Both ACKs rise together, sampled at edge e0: holds are captured and the FSM goes to PUSH.
  - At e1 the entry is written; VALID_OUT=1 and the data appear after e1.
  - Latency is 2 edges from the ACK sampling edge.
- ACKs rising at different edges: latency is 2 edges from the later ACK.
- Sustained throughput is one pair per 2 cycles, limited by the upstream ACK low/high cycle.
- A pop at edge e advances the head, so the next entry is on the DATA outputs after e.
- COUNT, FULL and EMPTY update on the same edge as the write or pop.

## Test plan
- Reset release with ACK_I=ACK_V=1 held, then both held high -> no entry; EMPTY=1, COUNT=0.
- ACK_I rises with RESULT_I=0x3F800000; ACK_V rises 3 cycles later with RESULT_V=0x40000000 -> 2 edges after the ACK_V edge, VALID_OUT=1 with DATA_I_OUT=0x3F800000 and DATA_V_OUT=0x40000000; pop with RD_EN -> EMPTY=1.
- ACK_I pulses twice (values 0x1, then 0x2) before ACK_V (0x3) -> single entry {0x2, 0x3}.
- 10 pairs with RD_EN=0 and DEPTH=8 -> COUNT=8, FULL=1, OVERFLOW=1, DROP_CNT=2; pop all 8 -> entries come out in order 1..8, and after that EMPTY=1.
- FULL, then a push coincident with RD_EN=1 -> no drop; COUNT stays 8; head advances.
- RST asserted mid-WAIT_V, then a fresh ACK_V rise -> FSM goes IDLE->WAIT_I and no entry is written. CLR_OVF with a simultaneous drop -> OVERFLOW=1, DROP_CNT=1.
